pssi_tx_8bus_32bits: RTL and testbench

- Transmit end of the 8-bit PSSI link: the FPGA drives byte data, data-enable and the PSSI clock towards the STM32H7 PSSI peripheral, which is configured in receive mode.
- Accepts 32-bit words (ADS8681 samples) over a valid/ready stream, buffers them in a small FIFO, and serializes each word into 4 consecutive bytes.
- Honours the STM32 RDY flow-control line.
- Sits between the ADC capture logic and the FPGA pins.

---
 rtl/pssi_tx_8bus_32bits.sv | 188 ++++++++++++++++++
 tb/tb_pssi_tx_8bus_32bits.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pssi_tx_8bus_32bits.sv
// PSSI 8-bit transmit serializer.
// Buffers 32-bit words in a small FIFO and shifts each one out as four
// consecutive bytes on an 8-bit PSSI bus, with data-enable and a divided
// PSSI clock. The receiver samples on the rising edge of pssi_clk_o, so
// bytes and DE change only on the falling edge (the "launch" edge).
//
// Ports:
//   clk_i, rst_ni        system clock, async active-low reset
//   s_data_i/s_valid_i   input word stream
//   s_ready_o            FIFO has room (registered)
//   pssi_clk_o           PSSI clock, period 2*CLK_DIV clk_i cycles
//   pssi_de_o            data-enable, active level DE_POL
//   pssi_data_o          PSSI byte
//   pssi_rdy_i           receiver ready, asynchronous, active high
//   busy_o               FIFO non-empty or word in flight
//   fifo_level_o         words waiting in the FIFO (not counting in-flight)
//
// state | meaning
// IDLE  | bus inactive, waiting for a word and rdy
// SEND  | bytes 0..2 of the current word on the bus
// LAST  | byte 3 on the bus; may chain straight into the next word
// PAUSE | rdy dropped mid-word; DE off, byte and index held

module pssi_tx_8bus_32bits #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 1,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit DE_POL     = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [31:0]                   s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic                          pssi_clk_o,
    output logic                          pssi_de_o,
    output logic [7:0]                    pssi_data_o,
    input  logic                          pssi_rdy_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, LAST, PAUSE} state_t;

    // PSSI clock divider: down-counter, toggle on terminal count.
    logic [DW-1:0] div_cnt;
    logic          pclk;
    logic          div_tc;
    logic          launch;

    assign div_tc = (div_cnt == '0);
    assign launch = div_tc && pclk;   // pssi_clk_o about to go 1->0

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= DIV_LOAD;
            pclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= DIV_LOAD;
            pclk    <= ~pclk;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // RDY synchronizer
    logic rdy_meta;
    logic rdy_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= pssi_rdy_i;
            rdy_s    <= rdy_meta;
        end
    end

    // Word FIFO
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic          push;
    logic          pop;
    logic          s_ready;
    logic [31:0]   head;
    state_t        state;

    assign push = s_valid_i && s_ready;
    assign pop  = launch && (level != '0) && rdy_s && ((state == IDLE) || (state == LAST));
    assign head = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

    // Depth is a power of two, so pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            s_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level   <= level_next;
            s_ready <= (level_next < DEPTH);
        end
    end

    // Byte k of a word in transmit order; MSB-first is just k reversed.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k);
        logic [1:0] slot;
        slot = LSB_FIRST ? k : ~k;
        return w[{slot, 3'b000} +: 8];
    endfunction

    // Serializer: acts only on launch edges, so outputs hold a full PSSI period.
    logic [31:0] cur_word;
    logic [1:0]  idx;
    logic [7:0]  data;
    logic        de;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cur_word <= '0;
            data     <= 8'h00;
            de       <= ~DE_POL;
        end else if (launch) begin
            case (state)
                IDLE, LAST: begin
                    if (pop) begin
                        cur_word <= head;
                        data     <= pick(head, 2'd0);
                        de       <= DE_POL;
                        idx      <= 2'd1;
                        state    <= SEND;
                    end else begin
                        de    <= ~DE_POL;
                        state <= IDLE;
                    end
                end
                SEND, PAUSE: begin
                    if (rdy_s) begin
                        data  <= pick(cur_word, idx);
                        de    <= DE_POL;
                        idx   <= idx + 2'd1;
                        state <= (idx == 2'd3) ? LAST : SEND;
                    end else begin
                        de    <= ~DE_POL;
                        state <= PAUSE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_ready_o    = s_ready;
    assign pssi_clk_o   = pclk;
    assign pssi_de_o    = de;
    assign pssi_data_o  = data;
    assign busy_o       = (level != '0) || (state != IDLE);
    assign fifo_level_o = level;

endmodule

// File: tb/tb_pssi_tx_8bus_32bits.sv
// Bench for pssi_tx_8bus_32bits. Instance A uses default parameters
// (LSB first, CLK_DIV=1, DE active high, depth 4); instance B uses MSB first,
// CLK_DIV=2, DE active low, depth 2. Expected bytes are queued when a word is
// accepted and popped by per-instance monitors at each PSSI rising edge with
// DE active.

module tb_pssi_tx_8bus_32bits;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni;

    logic [31:0] s_data_a;
    logic        s_valid_a;
    logic        s_ready_a;
    logic        pclk_a;
    logic        de_a;
    logic [7:0]  pdata_a;
    logic        rdy_a;
    logic        busy_a;
    logic [2:0]  level_a;

    logic [31:0] s_data_b;
    logic        s_valid_b;
    logic        s_ready_b;
    logic        pclk_b;
    logic        de_b;
    logic [7:0]  pdata_b;
    logic        rdy_b;
    logic        busy_b;
    logic [1:0]  level_b;

    pssi_tx_8bus_32bits dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_data_i(s_data_a), .s_valid_i(s_valid_a), .s_ready_o(s_ready_a),
        .pssi_clk_o(pclk_a), .pssi_de_o(de_a), .pssi_data_o(pdata_a),
        .pssi_rdy_i(rdy_a), .busy_o(busy_a), .fifo_level_o(level_a)
    );

    pssi_tx_8bus_32bits #(
        .FIFO_DEPTH(2), .CLK_DIV(2), .LSB_FIRST(1'b0), .DE_POL(1'b0)
    ) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_data_i(s_data_b), .s_valid_i(s_valid_b), .s_ready_o(s_ready_b),
        .pssi_clk_o(pclk_b), .pssi_de_o(de_b), .pssi_data_o(pdata_b),
        .pssi_rdy_i(rdy_b), .busy_o(busy_b), .fifo_level_o(level_b)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int cap_a = 0, run_a = 0, max_run_a = 0;
    int cap_b = 0, run_b = 0, max_run_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    logic [7:0] e_a, e_b;
    bit rand_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a word becomes four bytes in transmit order.
    function automatic void model_push(input bit b, input logic [31:0] w, input bit lsb);
        for (int k = 0; k < 4; k++) begin
            int sh;
            logic [7:0] v;
            sh = lsb ? k : 3 - k;
            v  = 8'((w >> (8 * sh)) & 32'hFF);
            if (b) exp_b.push_back(v);
            else   exp_a.push_back(v);
        end
    endfunction

    // Monitor A: DE active high
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_a = 1'b0;
                run_a  = 0;
            end else begin
                if (pclk_a && !prev_a) begin
                    if (de_a) begin
                        cap_a++;
                        run_a++;
                        if (run_a > max_run_a) max_run_a = run_a;
                        if (exp_a.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL a_unexpected_byte: got 0x%0h, no byte expected", pdata_a);
                        end else begin
                            e_a = exp_a.pop_front();
                            check("a_byte", pdata_a, e_a);
                        end
                    end else begin
                        run_a = 0;
                    end
                end
                prev_a = pclk_a;
            end
        end
    end

    // Monitor B: DE active low
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_b = 1'b0;
                run_b  = 0;
            end else begin
                if (pclk_b && !prev_b) begin
                    if (!de_b) begin
                        cap_b++;
                        run_b++;
                        if (run_b > max_run_b) max_run_b = run_b;
                        if (exp_b.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL b_unexpected_byte: got 0x%0h, no byte expected", pdata_b);
                        end else begin
                            e_b = exp_b.pop_front();
                            check("b_byte", pdata_b, e_b);
                        end
                    end else begin
                        run_b = 0;
                    end
                end
                prev_b = pclk_b;
            end
        end
    end

    task automatic write_word(input bit b, input logic [31:0] w);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        @(negedge clk_i);
        #1;
        if (b) begin s_data_b = w; s_valid_b = 1'b1; end
        else   begin s_data_a = w; s_valid_a = 1'b1; end
        while (!ok && n < 200) begin
            if (b ? s_ready_b : s_ready_a) begin
                @(posedge clk_i);
                ok = 1'b1;
            end else begin
                @(negedge clk_i);
                #1;
                n++;
            end
        end
        if (ok) model_push(b, w, b ? 1'b0 : 1'b1);
        #1;
        if (b) s_valid_b = 1'b0;
        else   s_valid_a = 1'b0;
        check(b ? "b_write_accepted" : "a_write_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input bit b, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk_i);
            #1;
            if (b) done = !busy_b && (exp_b.size() == 0);
            else   done = !busy_a && (exp_a.size() == 0);
        end
        check(b ? "b_drain" : "a_drain", 32'(done), 32'd1);
    endtask

    task automatic wait_cap_a(input int target, input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk_i);
            #1;
            done = (cap_a >= target);
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bit got;

        rst_ni    = 1'b0;
        rdy_a     = 1'b1;
        rdy_b     = 1'b1;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        s_data_a  = '0;
        s_data_b  = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_pclk_a", pclk_a, 0);
        check("rst_de_a", de_a, 0);
        check("rst_data_a", pdata_a, 0);
        check("rst_ready_a", s_ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_level_a", level_a, 0);
        check("rst_de_b", de_b, 1);
        check("rst_pclk_b", pclk_b, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);

        // Single word, LSB first
        base = cap_a;
        max_run_a = 0;
        write_word(0, 32'h4D3C2B1A);
        wait_drain(0, 200);
        check("t1_bytes", cap_a - base, 4);
        check("t1_de_run", max_run_a, 4);
        check("t1_de_idle", de_a, 0);
        check("t1_busy", busy_a, 0);

        // Two words back-to-back with no DE gap
        base = cap_a;
        max_run_a = 0;
        write_word(0, 32'h4D3C2B1A);
        write_word(0, 32'h88776655);
        wait_drain(0, 200);
        check("t2_bytes", cap_a - base, 8);
        check("t2_de_run", max_run_a, 8);

        // MSB first on instance B
        base = cap_b;
        max_run_b = 0;
        write_word(1, 32'h11223344);
        wait_drain(1, 200);
        check("t3_bytes", cap_b - base, 4);
        check("t3_de_run", max_run_b, 4);
        check("t3_de_idle", de_b, 1);

        // Fill FIFO with rdy low, then release
        rdy_a = 1'b0;
        repeat (6) @(negedge clk_i);
        base = cap_a;
        for (int i = 0; i < 4; i++) write_word(0, $urandom);
        @(negedge clk_i);
        #1;
        check("t4_level_full", level_a, 4);
        check("t4_ready_full", s_ready_a, 0);
        check("t4_busy", busy_a, 1);
        repeat (20) @(negedge clk_i);
        #1;
        check("t4_no_bytes", cap_a - base, 0);
        check("t4_level_held", level_a, 4);
        rdy_a = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk_i);
            #1;
            got = s_ready_a;
        end
        check("t4_ready_back", got, 1);
        check("t4_level_after_pop", level_a, 3);
        wait_drain(0, 400);
        check("t4_bytes", cap_a - base, 16);

        // rdy dropped right after byte 0 is captured; the synchronizer
        // latency lets byte 1 go out, so the bus freezes on 2B.
        base = cap_a;
        write_word(0, 32'h4D3C2B1A);
        wait_cap_a(base + 1, 100, "t5_first_byte");
        rdy_a = 1'b0;
        repeat (20) @(negedge clk_i);
        #1;
        check("t5_pause_de", de_a, 0);
        check("t5_pause_data", pdata_a, 8'h2B);
        check("t5_pause_count", cap_a - base, 2);
        check("t5_pause_busy", busy_a, 1);
        rdy_a = 1'b1;
        wait_drain(0, 200);
        check("t5_bytes", cap_a - base, 4);

        // Reset while 3C is on the bus, with a second word still queued
        write_word(0, 32'h4D3C2B1A);
        write_word(0, 32'hDEADBEEF);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk_i);
            #1;
            got = de_a && (pdata_a == 8'h3C);
        end
        check("t6_saw_3c", got, 1);
        check("t6_level_before", level_a, 1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_de", de_a, 0);
        check("t6_rst_data", pdata_a, 0);
        check("t6_rst_pclk", pclk_a, 0);
        check("t6_rst_level", level_a, 0);
        check("t6_rst_busy", busy_a, 0);
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        base = cap_a;
        max_run_a = 0;
        write_word(0, 32'hA5A5A5A5);
        wait_drain(0, 200);
        check("t6_bytes", cap_a - base, 4);
        check("t6_de_run", max_run_a, 4);

        // Random words with random rdy activity on A
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    write_word(0, $urandom);
                    repeat ($urandom_range(0, 12)) @(negedge clk_i);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    repeat ($urandom_range(1, 25)) @(negedge clk_i);
                    #2;
                    rdy_a = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rdy_a = 1'b1;
        wait_drain(0, 2000);

        // Random words on B with short rdy drops
        for (int i = 0; i < 10; i++) begin
            rdy_b = 1'b0;
            repeat ($urandom_range(1, 20)) @(negedge clk_i);
            rdy_b = 1'b1;
            write_word(1, $urandom);
        end
        wait_drain(1, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
